// File: rtl/fpga_top_sdiv_seq_16s_10ns_10.sv
// Sequential signed divider: 16-bit signed dividend by 10-bit unsigned divisor,
// one restoring step per cycle, saturated 10-bit quotient and 11-bit signed remainder.
module fpga_top_sdiv_seq_16s_10ns_10 #(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned din0_WIDTH = 32'd16,
    parameter int unsigned din1_WIDTH = 32'd10,
    parameter int unsigned dout_WIDTH = 32'd10
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  ovf,
    output logic                  div0
);

    localparam int DW = din0_WIDTH;
    localparam int VW = din1_WIDTH;
    localparam int QW = dout_WIDTH;
    localparam int CW = $clog2(DW);

    localparam logic [DW-1:0] Q_POS_LIMIT = DW'((1 << (QW - 1)) - 1);
    localparam logic [DW-1:0] Q_NEG_LIMIT = DW'(1 << (QW - 1));
    localparam logic [QW-1:0] DOUT_MAX    = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] DOUT_MIN    = {1'b1, {(QW-1){1'b0}}};
    localparam logic [CW-1:0] LAST_ITER   = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   dq_q;     // dividend bits shift out the top, quotient bits shift in
    logic [VW-1:0]   pr_q;
    logic [VW-1:0]   dvs_q;
    logic            neg_q;
    logic            zero_q;
    logic [QW-1:0]   dout_q;
    logic [VW:0]     rem_q;
    logic            ovf_q;
    logic            div0_q;
    logic            done_q;

    logic [DW-1:0]   din0_mag;
    logic [VW:0]     trial;
    logic [VW-1:0]   diff;
    logic            take;
    logic [VW-1:0]   pr_d;
    logic [DW-1:0]   dq_d;
    logic [QW-1:0]   dout_d;
    logic [VW:0]     rem_d;
    logic            ovf_d;

    // NOTE: ap_ready is decoded combinationally so the accept is visible in the same cycle as ap_start.
    assign ap_ready = (state_q == IDLE) & ap_start;
    assign ap_idle  = (state_q == IDLE);
    assign ap_done  = done_q;
    assign dout     = dout_q;
    assign rem      = rem_q;
    assign ovf      = ovf_q;
    assign div0     = div0_q;

    // Two's-complement magnitude; -32768 maps to 16'h8000, which is exact as unsigned.
    assign din0_mag = din0[DW-1] ? (~din0 + 1'b1) : din0;

    assign trial = {pr_q, dq_q[DW-1]};
    assign take  = (trial >= {1'b0, dvs_q});
    // The true difference is below the divisor, so modulo-2^VW arithmetic is exact.
    assign diff  = trial[VW-1:0] - dvs_q;
    assign pr_d  = take ? diff : trial[VW-1:0];
    assign dq_d  = {dq_q[DW-2:0], take};

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        dout_d = '0;
        rem_d  = '0;
        ovf_d  = 1'b0;
        if (zero_q) begin
            dout_d = neg_q ? DOUT_MIN : DOUT_MAX;
        end else if (neg_q) begin
            rem_d = ~{1'b0, pr_q} + 1'b1;
            if (dq_q > Q_NEG_LIMIT) begin
                dout_d = DOUT_MIN;
                ovf_d  = 1'b1;
            end else begin
                dout_d = ~dq_q[QW-1:0] + 1'b1;
            end
        end else begin
            rem_d = {1'b0, pr_q};
            if (dq_q > Q_POS_LIMIT) begin
                dout_d = DOUT_MAX;
                ovf_d  = 1'b1;
            end else begin
                dout_d = dq_q[QW-1:0];
            end
        end
    end

    // NOTE: datapath registers are reset along with control so outputs read zero during reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            pr_q    <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        dq_q    <= din0_mag;
                        pr_q    <= '0;
                        dvs_q   <= din1;
                        neg_q   <= din0[DW-1];
                        zero_q  <= (din1 == '0);
                        cnt_q   <= '0;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    dq_q  <= dq_d;
                    pr_q  <= pr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    dout_q  <= dout_d;
                    rem_q   <= rem_d;
                    ovf_q   <= ovf_d;
                    div0_q  <= zero_q;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    a_done_only_in_done: assert property (
        @(posedge ap_clk) disable iff (!ap_rst_n) done_q == (state_q == DONE)
    ) else $error("sdiv %0d: ap_done outside DONE", ID);

    a_partial_rem_bound: assert property (
        @(posedge ap_clk) disable iff (!ap_rst_n) (state_q != IDLE && !zero_q) |-> (pr_q < dvs_q)
    ) else $error("sdiv %0d: partial remainder not below divisor", ID);

endmodule

// File: tb/tb_fpga_top_sdiv_seq_16s_10ns_10.sv
// Scoreboard bench for the sequential signed divider: directed vectors push
// expected results; a negedge monitor pops and compares on every ap_done.
module tb_fpga_top_sdiv_seq_16s_10ns_10;

    logic              ap_clk;
    logic              ap_rst_n;
    logic              ap_start;
    logic              ap_ready;
    logic              ap_idle;
    logic              ap_done;
    logic signed [15:0] din0;
    logic [9:0]        din1;
    logic [9:0]        dout;
    logic [10:0]       rem;
    logic              ovf;
    logic              div0;

    fpga_top_sdiv_seq_16s_10ns_10 dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .rem      (rem),
        .ovf      (ovf),
        .div0     (div0)
    );

    typedef struct {
        string nm;
        int    q;
        int    r;
        int    o;
        int    z;
        int    due;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   done_times[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   cyc      = 0;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc++;

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Monitor: compares on every done pulse, independent of the stimulus process.
    always @(negedge ap_clk) begin
        if (ap_rst_n && ap_done) begin
            n_done++;
            done_times.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                last_exp = e;
                check({e.nm, "_dout"},    int'($signed(dout)), e.q);
                check({e.nm, "_rem"},     int'($signed(rem)),  e.r);
                check({e.nm, "_ovf"},     int'(ovf),           e.o);
                check({e.nm, "_div0"},    int'(div0),          e.z);
                check({e.nm, "_latency"}, cyc,                 e.due);
            end
        end
    end

    task automatic push_exp(input string nm, input int q, input int r, input int o, input int z);
        exp_t e;
        e.nm = nm; e.q = q; e.r = r; e.o = o; e.z = z;
        e.due = cyc + 18;
        sb.push_back(e);
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge ap_clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("timeout_waiting_done", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic issue(input string nm, input int a, input int b,
                         input int q, input int r, input int o, input int z);
        @(negedge ap_clk);
        ap_start = 1'b1;
        din0     = 16'(a);
        din1     = 10'(b);
        #1;
        check({nm, "_ready"}, int'(ap_ready), 1);
        push_exp(nm, q, r, o, z);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        din0     = 16'($urandom);
        din1     = 10'($urandom);
        wait_empty();
        // Results must hold after the done pulse.
        @(negedge ap_clk);
        check({nm, "_hold"}, int'($signed(dout)), last_exp.q);
    endtask

    typedef struct {
        string nm;
        int a, b, q, r, o, z;
    } vec_t;

    vec_t vecs[$] = '{
        '{"p1000_7",    1000,   7,    142,   6,  0, 0},
        '{"n1000_7",   -1000,   7,   -142,  -6,  0, 0},
        '{"n5120_10",  -5120,  10,   -512,   0,  0, 0},
        '{"p5120_10",   5120,  10,    511,   0,  1, 0},
        '{"p32767_3",  32767,   3,    511,   1,  1, 0},
        '{"n32768_1", -32768,   1,   -512,   0,  1, 0},
        '{"p100_0",      100,   0,    511,   0,  0, 1},
        '{"n5_0",         -5,   0,   -512,   0,  0, 1},
        '{"p0_0",          0,   0,    511,   0,  0, 1},
        '{"n7_2",         -7,   2,     -3,  -1,  0, 0},
        '{"p511_1",      511,   1,    511,   0,  0, 0},
        '{"p512_1",      512,   1,    511,   0,  1, 0},
        '{"n512_1",     -512,   1,   -512,   0,  0, 0},
        '{"n513_1",     -513,   1,   -512,   0,  1, 0},
        '{"p300_1023",   300, 1023,     0, 300,  0, 0},
        '{"n1_1023",      -1, 1023,     0,  -1,  0, 0},
        '{"p32767_1023", 32767, 1023,  32,  31,  0, 0},
        '{"n32768_1023", -32768, 1023, -32, -32, 0, 0}
    };

    vec_t busy_ops[3] = '{
        '{"busy_200_9",   200, 9,   22,  2, 0, 0},
        '{"busy_n300_7", -300, 7,  -42, -6, 0, 0},
        '{"busy_1234_1", 1234, 1,  511,  0, 1, 0}
    };

    initial begin
        int dn_before;
        int nd;
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(negedge ap_clk);
        check("rst_idle",  int'(ap_idle),  1);
        check("rst_ready", int'(ap_ready), 0);
        check("rst_done",  int'(ap_done),  0);
        check("rst_dout",  int'(dout),     0);
        check("rst_rem",   int'(rem),      0);
        check("rst_flags", int'({ovf, div0}), 0);
        ap_rst_n = 1'b1;

        foreach (vecs[i])
            issue(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].z);

        // Abort 1000/7 with a reset eight cycles after accept; no done may follow for it.
        @(negedge ap_clk);
        ap_start = 1'b1;
        din0 = 16'sd1000;
        din1 = 10'd7;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        dn_before = n_done;
        repeat (8) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("abort_idle",  int'(ap_idle), 1);
        check("abort_dout",  int'(dout),    0);
        check("abort_done",  int'(ap_done), 0);
        check("abort_ready_lo", int'(ap_ready), 0);
        ap_start = 1'b1;
        #1;
        check("abort_ready_hi", int'(ap_ready), 1);
        @(negedge ap_clk);
        din0 = 16'sd50;
        din1 = 10'd5;
        ap_rst_n = 1'b1;
        push_exp("post_reset_50_5", 10, 0, 0, 0);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        wait_empty();
        check("abort_done_count", n_done - dn_before, 1);

        // Held start with operands toggling while busy.
        nd = done_times.size();
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int t = 0; t < 57; t++) begin
            if (t % 19 == 0) begin
                din0 = 16'(busy_ops[t / 19].a);
                din1 = 10'(busy_ops[t / 19].b);
                push_exp(busy_ops[t / 19].nm, busy_ops[t / 19].q, busy_ops[t / 19].r,
                         busy_ops[t / 19].o, busy_ops[t / 19].z);
            end else begin
                din0 = 16'($urandom);
                din1 = 10'($urandom);
            end
            #1;
            check("busy_ready_slot", int'(ap_ready), int'(t % 19 == 0));
            @(negedge ap_clk);
        end
        ap_start = 1'b0;
        wait_empty();
        check("busy_done_count", done_times.size() - nd, 3);
        if (done_times.size() - nd == 3) begin
            check("busy_spacing_1", done_times[nd + 1] - done_times[nd], 19);
            check("busy_spacing_2", done_times[nd + 2] - done_times[nd + 1], 19);
        end

        repeat (3) @(negedge ap_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
